// File: rtl/overture_io_pkg.sv
// Shared defaults, status-word layout and CPU access decode type for the
// overture I/O hub.
package overture_io_pkg;

   localparam int DEF_WIDTH    = 8;
   localparam int DEF_CHANNELS = 4;
   localparam int DEF_DEPTH    = 4;

   // Status word: input-not-empty flags first, output-not-full flags after them.
   localparam int STAT_IN_OFS  = 0;

   function automatic int stat_out_ofs(input int channels);
      return STAT_IN_OFS + channels;
   endfunction

   typedef enum logic [1:0] {
      ACC_NONE   = 2'd0,
      ACC_STATUS = 2'd1,
      ACC_DATA   = 2'd2,
      ACC_BAD_CH = 2'd3
   } acc_kind_e;

endpackage

// File: rtl/overture_io_fifo.sv
// First-word-fall-through FIFO with wrapping pointers and a flush that
// overrides any same-cycle push or pop.
module overture_io_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             empty_o,
   output logic             full_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push_s, do_pop_s;

   assign empty_o   = (count_q == {CW{1'b0}});
   assign full_o    = (count_q == CW'(DEPTH));
   assign rdata_o   = mem_q[rd_ptr_q];
   assign do_push_s = push_i & ~full_o;
   assign do_pop_s  = pop_i & ~empty_o;

   // Pointer and occupancy next-state
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = {PW{1'b0}};
         rd_ptr_d = {PW{1'b0}};
         count_d  = {CW{1'b0}};
      end else begin
         if (do_push_s) wr_ptr_d = wr_ptr_q + PW'(1);
         else           wr_ptr_d = wr_ptr_q;
         if (do_pop_s)  rd_ptr_d = rd_ptr_q + PW'(1);
         else           rd_ptr_d = rd_ptr_q;
         case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= {PW{1'b0}};
         rd_ptr_q <= {PW{1'b0}};
         count_q  <= {CW{1'b0}};
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= {WIDTH{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (!flush_i && do_push_s) mem_q[wr_ptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/overture_io_hub.sv
// CPU-facing I/O hub: per-channel input and output FIFOs, a stalling data
// port for the CPU and a status/flush register at the upper address half.
module overture_io_hub
   import overture_io_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int CHANNELS = DEF_CHANNELS,
   parameter int DEPTH    = DEF_DEPTH,
   localparam int AW      = $clog2(CHANNELS) + 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      cpu_rd,
   input  logic                      cpu_wr,
   input  logic [AW-1:0]             cpu_addr,
   input  logic [WIDTH-1:0]          cpu_wdata,
   output logic [WIDTH-1:0]          cpu_rdata,
   output logic                      stall,
   input  logic [CHANNELS-1:0]       in_valid,
   output logic [CHANNELS-1:0]       in_ready,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   output logic [CHANNELS-1:0]       out_valid,
   input  logic [CHANNELS-1:0]       out_ready,
   output logic [CHANNELS*WIDTH-1:0] out_data
);

   localparam int            OUT_OFS  = stat_out_ofs(CHANNELS);
   localparam logic [AW-1:0] CH_LIMIT = AW'(CHANNELS);

   acc_kind_e             acc_s;
   logic [AW-1:0]         ch_s;
   logic                  rd_s, wr_s;
   logic [CHANNELS-1:0]   sel_s;
   logic [CHANNELS-1:0]   in_empty_s, in_full_s, in_push_s, in_pop_s, in_flush_s;
   logic [CHANNELS-1:0]   out_empty_s, out_full_s, out_push_s, out_pop_s, out_flush_s;
   logic [WIDTH-1:0]      in_head_s [CHANNELS];
   logic [WIDTH-1:0]      head_sel_s, status_s;
   logic                  data_ne_s, stall_s;
   logic [WIDTH-1:0]      rdata_q, rdata_d;

   if (AW > 1) begin : g_ch_idx
      assign ch_s = {1'b0, cpu_addr[AW-2:0]};
   end else begin : g_ch_one
      assign ch_s = {AW{1'b0}};
   end

   // A simultaneous read and write is treated as the write alone.
   assign wr_s = cpu_wr;
   assign rd_s = cpu_rd & ~cpu_wr;

   // Access classification
   always_comb begin
      acc_s = ACC_NONE;
      if (!(cpu_rd || cpu_wr))    acc_s = ACC_NONE;
      else if (cpu_addr[AW-1])    acc_s = ACC_STATUS;
      else if (ch_s < CH_LIMIT)   acc_s = ACC_DATA;
      else                        acc_s = ACC_BAD_CH;
   end

   // FIFO control, stall and status word; all decisions use registered FIFO flags
   always_comb begin
      sel_s       = {CHANNELS{1'b0}};
      in_pop_s    = {CHANNELS{1'b0}};
      out_push_s  = {CHANNELS{1'b0}};
      in_flush_s  = {CHANNELS{1'b0}};
      out_flush_s = {CHANNELS{1'b0}};
      stall_s     = 1'b0;
      head_sel_s  = {WIDTH{1'b0}};
      data_ne_s   = 1'b0;
      status_s    = {WIDTH{1'b0}};
      for (int i = 0; i < CHANNELS; i++) begin
         sel_s[i]       = (acc_s == ACC_DATA) && (ch_s == AW'(i));
         in_pop_s[i]    = sel_s[i] & rd_s & ~in_empty_s[i];
         out_push_s[i]  = sel_s[i] & wr_s & ~out_full_s[i];
         in_flush_s[i]  = (acc_s == ACC_STATUS) & wr_s & cpu_wdata[STAT_IN_OFS + i];
         out_flush_s[i] = (acc_s == ACC_STATUS) & wr_s & cpu_wdata[OUT_OFS + i];
         stall_s        = stall_s | (sel_s[i] & ((wr_s & out_full_s[i]) | (rd_s & in_empty_s[i])));
         head_sel_s     = head_sel_s | ({WIDTH{sel_s[i]}} & in_head_s[i]);
         data_ne_s      = data_ne_s | (sel_s[i] & ~in_empty_s[i]);
         status_s[STAT_IN_OFS + i] = ~in_empty_s[i];
         status_s[OUT_OFS + i]     = ~out_full_s[i];
      end
   end

   // Read data next-state
   always_comb begin
      rdata_d = rdata_q;
      case (acc_s)
         ACC_STATUS: if (rd_s)              rdata_d = status_s;   else rdata_d = rdata_q;
         ACC_DATA:   if (rd_s && data_ne_s) rdata_d = head_sel_s; else rdata_d = rdata_q;
         ACC_BAD_CH: if (rd_s)              rdata_d = {WIDTH{1'b0}}; else rdata_d = rdata_q;
         default:                           rdata_d = rdata_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) rdata_q <= {WIDTH{1'b0}};
      else       rdata_q <= rdata_d;
   end

   assign cpu_rdata = rdata_q;
   assign stall     = stall_s;
   assign in_ready  = ~in_full_s & {CHANNELS{~reset}};
   assign out_valid = ~out_empty_s;
   assign in_push_s = in_valid & in_ready;
   assign out_pop_s = out_ready & out_valid;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      overture_io_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_in_fifo (
         .clk     (clk),
         .reset   (reset),
         .flush_i (in_flush_s[g]),
         .push_i  (in_push_s[g]),
         .wdata_i (in_data[g*WIDTH +: WIDTH]),
         .pop_i   (in_pop_s[g]),
         .rdata_o (in_head_s[g]),
         .empty_o (in_empty_s[g]),
         .full_o  (in_full_s[g])
      );

      overture_io_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_out_fifo (
         .clk     (clk),
         .reset   (reset),
         .flush_i (out_flush_s[g]),
         .push_i  (out_push_s[g]),
         .wdata_i (cpu_wdata),
         .pop_i   (out_pop_s[g]),
         .rdata_o (out_data[g*WIDTH +: WIDTH]),
         .empty_o (out_empty_s[g]),
         .full_o  (out_full_s[g])
      );
   end

endmodule
